// File: rtl/banco_registros_sb_if.sv
// Register-bank bus: two read ports with busy flags, one write port,
// one reservation port and the live busy count.
interface banco_registros_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] R_register_1;
    logic [ADDR_W-1:0] R_register_2;
    logic [DATA_W-1:0] R_data_1;
    logic [DATA_W-1:0] R_data_2;
    logic              R_busy_1;
    logic              R_busy_2;
    logic [ADDR_W-1:0] W_register;
    logic [DATA_W-1:0] W_data;
    logic              RegEn;
    logic [ADDR_W-1:0] Rsv_register;
    logic              RsvEn;
    logic [ADDR_W:0]   busy_count;

    // Datapath / hazard unit side
    modport master (
        output R_register_1, R_register_2, W_register, W_data, RegEn,
               Rsv_register, RsvEn,
        input  R_data_1, R_data_2, R_busy_1, R_busy_2, busy_count
    );

    // Register bank side
    modport slave (
        input  R_register_1, R_register_2, W_register, W_data, RegEn,
               Rsv_register, RsvEn,
        output R_data_1, R_data_2, R_busy_1, R_busy_2, busy_count
    );
endinterface

// File: rtl/banco_registros_sb.sv
// Register bank with two combinational read ports, one synchronous write
// port, optional hard-wired zero register, write-to-read bypass and a
// per-register busy scoreboard with a registered busy count.
module banco_registros_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    banco_registros_sb_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // Registers need a whole-array asynchronous clear, so they are flops
    // rather than block RAM.
    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]  busy_reg;
    logic [DEPTH-1:0]  busy_next;
    logic [ADDR_W:0]   busy_count_reg;
    logic [ADDR_W:0]   busy_count_next;

    // One-hot decode of the write and reservation targets. Register 0 never
    // decodes when it is hard-wired, so it is never written nor reserved;
    // its flop stays at its reset value of zero, which makes reads of r0
    // return 0 and not-busy without any extra read-side logic.
    logic [DEPTH-1:0] wr_hit;
    logic [DEPTH-1:0] rsv_hit;

    logic set_new;
    logic clr_old;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            if (ZERO_REG != 0 && gi == 0) begin : g_zero
                assign wr_hit[gi]  = 1'b0;
                assign rsv_hit[gi] = 1'b0;
            end else begin : g_norm
                assign wr_hit[gi]  = bus.RegEn && (bus.W_register == ADDR_W'(gi));
                assign rsv_hit[gi] = bus.RsvEn && (bus.Rsv_register == ADDR_W'(gi));
            end
            // A fresh reservation beats a same-edge release.
            assign busy_next[gi] = rsv_hit[gi] | (busy_reg[gi] & ~wr_hit[gi]);
        end
    endgenerate

    // Net change of the count: a reservation of an idle register adds one,
    // a write releasing a busy register (not re-reserved) removes one.
    assign set_new = |(rsv_hit & ~busy_reg);
    assign clr_old = |(wr_hit & busy_reg & ~rsv_hit);
    assign busy_count_next = busy_count_reg
                           + {{ADDR_W{1'b0}}, set_new}
                           - {{ADDR_W{1'b0}}, clr_old};

    // Register array, scoreboard and busy count; all cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
            busy_reg       <= '0;
            busy_count_reg <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_hit[i]) begin
                    mem_reg[i] <= bus.W_data;
                end
            end
            busy_reg       <= busy_next;
            busy_count_reg <= busy_count_next;
        end
    end

    // Read port 1: array value, or the in-flight write data when forwarding.
    // Forwarded data also hides the busy flag unless the same register is
    // being re-reserved this cycle.
    always_comb begin
        bus.R_data_1 = mem_reg[bus.R_register_1];
        bus.R_busy_1 = busy_reg[bus.R_register_1];
        if (BYPASS != 0 && wr_hit[bus.R_register_1]) begin
            bus.R_data_1 = bus.W_data;
            if (!rsv_hit[bus.R_register_1]) begin
                bus.R_busy_1 = 1'b0;
            end
        end
    end

    // Read port 2: same behaviour as port 1, fully independent.
    always_comb begin
        bus.R_data_2 = mem_reg[bus.R_register_2];
        bus.R_busy_2 = busy_reg[bus.R_register_2];
        if (BYPASS != 0 && wr_hit[bus.R_register_2]) begin
            bus.R_data_2 = bus.W_data;
            if (!rsv_hit[bus.R_register_2]) begin
                bus.R_busy_2 = 1'b0;
            end
        end
    end

    assign bus.busy_count = busy_count_reg;

endmodule

// File: tb/tb_banco_registros_sb.sv
// Bench for banco_registros_sb: a 32x32 bypassing instance and a 8x16
// non-bypassing instance, driven from vector tables, hand sequences and
// random traffic checked against an array/popcount reference model.
module tb_banco_registros_sb;

    logic clk;
    logic rst_n;

    banco_registros_sb_if #(.DATA_W(32), .ADDR_W(5)) b32 ();
    banco_registros_sb_if #(.DATA_W(16), .ADDR_W(3)) b16 ();

    banco_registros_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32.slave)
    );

    banco_registros_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        bit          wen;
        logic [4:0]  rsvreg;
        bit          rsven;
        logic [31:0] e_d1;
        logic [31:0] e_d2;
        bit          e_b1;
        bit          e_b2;
        int          e_cnt;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain register contents and busy flags per instance
    logic [31:0] m_mem  [2][32];
    bit          m_busy [2][32];

    function automatic vec_t mk(logic [4:0] r1, logic [4:0] r2, logic [4:0] wreg,
                                logic [31:0] wdata, bit wen, logic [4:0] rsvreg, bit rsven,
                                logic [31:0] e_d1, logic [31:0] e_d2, bit e_b1, bit e_b2,
                                int e_cnt);
        vec_t v;
        v.r1 = r1; v.r2 = r2; v.wreg = wreg; v.wdata = wdata; v.wen = wen;
        v.rsvreg = rsvreg; v.rsven = rsven; v.e_d1 = e_d1; v.e_d2 = e_d2;
        v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] m_rd(int d, logic [4:0] a, vec_t v);
        if (a == 0) return 32'h0;
        if (d == 0 && v.wen && v.wreg == a) return v.wdata;
        return m_mem[d][a];
    endfunction

    function automatic bit m_bz(int d, logic [4:0] a, vec_t v);
        if (a == 0) return 1'b0;
        if (d == 0 && v.wen && v.wreg == a && !(v.rsven && v.rsvreg == a)) return 1'b0;
        return m_busy[d][a];
    endfunction

    function automatic int m_cnt(int d);
        int s = 0;
        for (int i = 0; i < 32; i++) s += int'(m_busy[d][i]);
        return s;
    endfunction

    task automatic m_clear();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 32; i++) begin
                m_mem[d][i]  = 32'h0;
                m_busy[d][i] = 1'b0;
            end
    endtask

    task automatic idle_all();
        b32.R_register_1 = '0; b32.R_register_2 = '0; b32.W_register = '0;
        b32.W_data = '0; b32.RegEn = 1'b0; b32.Rsv_register = '0; b32.RsvEn = 1'b0;
        b16.R_register_1 = '0; b16.R_register_2 = '0; b16.W_register = '0;
        b16.W_data = '0; b16.RegEn = 1'b0; b16.Rsv_register = '0; b16.RsvEn = 1'b0;
    endtask

    // One cycle on instance d (0: 32-bit, 1: 16-bit). Entered just after a
    // rising edge; returns just after the next one with the model updated.
    task automatic run_vec(int d, vec_t vin, bit use_tab, string tag);
        vec_t        v;
        logic [4:0]  amask;
        logic [31:0] e_d1, e_d2, a_d1, a_d2, a_cnt;
        bit          e_b1, e_b2, a_b1, a_b2;
        int          e_cnt;
        v = vin;
        amask = (d == 0) ? 5'd31 : 5'd7;
        v.r1 &= amask; v.r2 &= amask; v.wreg &= amask; v.rsvreg &= amask;
        if (d == 1) v.wdata &= 32'h0000_FFFF;
        if (d == 0) begin
            b32.R_register_1 = v.r1; b32.R_register_2 = v.r2;
            b32.W_register = v.wreg; b32.W_data = v.wdata; b32.RegEn = v.wen;
            b32.Rsv_register = v.rsvreg; b32.RsvEn = v.rsven;
            b16.RegEn = 1'b0; b16.RsvEn = 1'b0;
        end else begin
            b16.R_register_1 = v.r1[2:0]; b16.R_register_2 = v.r2[2:0];
            b16.W_register = v.wreg[2:0]; b16.W_data = v.wdata[15:0]; b16.RegEn = v.wen;
            b16.Rsv_register = v.rsvreg[2:0]; b16.RsvEn = v.rsven;
            b32.RegEn = 1'b0; b32.RsvEn = 1'b0;
        end
        #2;
        if (use_tab) begin
            e_d1 = v.e_d1; e_d2 = v.e_d2; e_b1 = v.e_b1; e_b2 = v.e_b2; e_cnt = v.e_cnt;
        end else begin
            e_d1 = m_rd(d, v.r1, v); e_d2 = m_rd(d, v.r2, v);
            e_b1 = m_bz(d, v.r1, v); e_b2 = m_bz(d, v.r2, v);
            e_cnt = m_cnt(d);
        end
        if (d == 0) begin
            a_d1 = b32.R_data_1; a_d2 = b32.R_data_2;
            a_b1 = b32.R_busy_1; a_b2 = b32.R_busy_2;
            a_cnt = {26'h0, b32.busy_count};
        end else begin
            a_d1 = {16'h0, b16.R_data_1}; a_d2 = {16'h0, b16.R_data_2};
            a_b1 = b16.R_busy_1; a_b2 = b16.R_busy_2;
            a_cnt = {28'h0, b16.busy_count};
        end
        chk($sformatf("%s R_data_1", tag), a_d1, e_d1);
        chk($sformatf("%s R_data_2", tag), a_d2, e_d2);
        chk($sformatf("%s R_busy_1", tag), {31'h0, a_b1}, {31'h0, e_b1});
        chk($sformatf("%s R_busy_2", tag), {31'h0, a_b2}, {31'h0, e_b2});
        chk($sformatf("%s busy_count", tag), a_cnt, 32'(e_cnt));
        @(posedge clk);
        if (v.wen && v.wreg != 0) begin
            m_mem[d][v.wreg]  = v.wdata;
            m_busy[d][v.wreg] = 1'b0;
        end
        if (v.rsven && v.rsvreg != 0) m_busy[d][v.rsvreg] = 1'b1;
        #1;
    endtask

    vec_t tab32 [19];
    vec_t tab16 [4];
    vec_t tail16 [3];
    vec_t rv;

    initial begin
        // r1 r2 wreg wdata wen rsv rsven | d1 d2 b1 b2 cnt
        tab32[0]  = mk(7, 0, 7, 32'h12345678, 1, 0, 0, 32'h12345678, 32'h0, 0, 0, 0);
        tab32[1]  = mk(7, 7, 0, 32'h0, 0, 0, 0, 32'h12345678, 32'h12345678, 0, 0, 0);
        tab32[2]  = mk(0, 7, 0, 32'hFFFFFFFF, 1, 0, 1, 32'h0, 32'h12345678, 0, 0, 0);
        tab32[3]  = mk(0, 7, 0, 32'h0, 0, 0, 0, 32'h0, 32'h12345678, 0, 0, 0);
        tab32[4]  = mk(7, 3, 0, 32'h0, 0, 3, 1, 32'h12345678, 32'h0, 0, 0, 0);
        tab32[5]  = mk(7, 3, 0, 32'h0, 0, 0, 0, 32'h12345678, 32'h0, 0, 1, 1);
        tab32[6]  = mk(3, 3, 3, 32'hA5, 1, 0, 0, 32'hA5, 32'hA5, 0, 0, 1);
        tab32[7]  = mk(3, 3, 0, 32'h0, 0, 0, 0, 32'hA5, 32'hA5, 0, 0, 0);
        tab32[8]  = mk(9, 3, 0, 32'h0, 0, 9, 1, 32'h0, 32'hA5, 0, 0, 0);
        tab32[9]  = mk(9, 3, 0, 32'h0, 0, 0, 0, 32'h0, 32'hA5, 1, 0, 1);
        tab32[10] = mk(9, 9, 9, 32'h55, 1, 9, 1, 32'h55, 32'h55, 1, 1, 1);
        tab32[11] = mk(9, 9, 0, 32'h0, 0, 0, 0, 32'h55, 32'h55, 1, 1, 1);
        tab32[12] = mk(9, 0, 9, 32'h66, 1, 0, 0, 32'h66, 32'h0, 0, 0, 1);
        tab32[13] = mk(9, 0, 0, 32'h0, 0, 0, 0, 32'h66, 32'h0, 0, 0, 0);
        tab32[14] = mk(4, 0, 0, 32'h0, 0, 4, 1, 32'h0, 32'h0, 0, 0, 0);
        tab32[15] = mk(4, 0, 0, 32'h0, 0, 4, 1, 32'h0, 32'h0, 1, 0, 1);
        tab32[16] = mk(4, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0, 1);
        tab32[17] = mk(4, 5, 4, 32'h1, 1, 5, 1, 32'h1, 32'h0, 0, 0, 1);
        tab32[18] = mk(4, 5, 0, 32'h0, 0, 0, 0, 32'h1, 32'h0, 0, 1, 1);

        tab16[0]  = mk(2, 0, 2, 32'hBEEF, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0);
        tab16[1]  = mk(2, 0, 0, 32'h0, 0, 0, 0, 32'hBEEF, 32'h0, 0, 0, 0);
        tab16[2]  = mk(2, 0, 2, 32'h1234, 1, 2, 1, 32'hBEEF, 32'h0, 0, 0, 0);
        tab16[3]  = mk(2, 0, 0, 32'h0, 0, 0, 0, 32'h1234, 32'h0, 1, 0, 1);

        tail16[0] = mk(0, 7, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 1, 7);
        tail16[1] = mk(3, 0, 3, 32'h7777, 1, 0, 0, 32'h0, 32'h0, 1, 0, 7);
        tail16[2] = mk(3, 0, 0, 32'h0, 0, 0, 0, 32'h7777, 32'h0, 0, 0, 6);

        idle_all();
        m_clear();
        b32.R_register_1 = 5'd1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset R_data_1", b32.R_data_1, 32'h0);
        chk("reset R_busy_1", {31'h0, b32.R_busy_1}, 32'h0);
        chk("reset busy_count", {26'h0, b32.busy_count}, 32'h0);
        chk("reset busy_count16", {28'h0, b16.busy_count}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 19; i++) run_vec(0, tab32[i], 1'b1, $sformatf("t32[%0d]", i));
        for (int i = 0; i < 4; i++)  run_vec(1, tab16[i], 1'b1, $sformatf("t16[%0d]", i));
        for (int i = 0; i < 8; i++) begin
            rv = mk(5'(i), 0, 0, 32'h0, 0, 5'(i), 1, 0, 0, 0, 0, 0);
            run_vec(1, rv, 1'b0, $sformatf("rsv16[%0d]", i));
        end
        for (int i = 0; i < 3; i++) run_vec(1, tail16[i], 1'b1, $sformatf("tail16[%0d]", i));

        // Random traffic, addresses biased towards a small window for collisions
        for (int i = 0; i < 400; i++) begin
            rv = mk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom), 0, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) rv.r1 = rv.wreg;
            if ($urandom_range(0, 3) == 0) rv.rsvreg = rv.wreg;
            run_vec(0, rv, 1'b0, $sformatf("rnd32[%0d]", i));
        end
        for (int i = 0; i < 200; i++) begin
            rv = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), $urandom, 1'($urandom),
                    5'($urandom_range(0, 7)), 1'($urandom), 0, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) rv.r1 = rv.wreg;
            run_vec(1, rv, 1'b0, $sformatf("rnd16[%0d]", i));
        end

        // Asynchronous reset mid-cycle after writing and reserving r5
        rv = mk(5, 0, 5, 32'hDEADBEEF, 1, 5, 1, 0, 0, 0, 0, 0);
        run_vec(0, rv, 1'b0, "pre_rst");
        b32.R_register_1 = 5'd5; b32.RegEn = 1'b0; b32.RsvEn = 1'b0;
        #2;
        chk("pre_rst r5 stored", b32.R_data_1, 32'hDEADBEEF);
        chk("pre_rst r5 busy", {31'h0, b32.R_busy_1}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst R_data_1", b32.R_data_1, 32'h0);
        chk("async_rst R_busy_1", {31'h0, b32.R_busy_1}, 32'h0);
        chk("async_rst busy_count", {26'h0, b32.busy_count}, 32'h0);
        chk("async_rst busy_count16", {28'h0, b16.busy_count}, 32'h0);
        // A write and reservation presented while in reset are lost
        b32.W_register = 5'd6; b32.W_data = 32'h99; b32.RegEn = 1'b1;
        b32.Rsv_register = 5'd6; b32.RsvEn = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        b32.RegEn = 1'b0; b32.RsvEn = 1'b0; b32.R_register_1 = 5'd6;
        #1;
        chk("rst_lost R_data_1", b32.R_data_1, 32'h0);
        chk("rst_lost R_busy_1", {31'h0, b32.R_busy_1}, 32'h0);
        chk("rst_lost busy_count", {26'h0, b32.busy_count}, 32'h0);
        m_clear();
        @(posedge clk);
        #1;
        rv = mk(6, 7, 7, 32'hCAFE, 1, 6, 1, 0, 0, 0, 0, 0);
        run_vec(0, rv, 1'b0, "post_rst");
        rv = mk(6, 7, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_vec(0, rv, 1'b0, "post_rst2");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
